calc1_port_sequencer: RTL and testbench
=======================================

Name: calc1_port_sequencer

Overview:
Upstream request sequencer for one calc1 port. It buffers whole operations (cmd, op1, op2) in a small FIFO and drives the calc1 two-cycle request protocol: cmd with op1, then op2. It waits for the port response and returns it through a valid/ready result interface. Four instances, one per calc1 port, replace hand-timed stimulus on reqN_cmd_in/reqN_data_in.

Parameters:
DEPTH, 4, request FIFO entries; power of 2, at least 2
TIMEOUT, 15, maximum WAIT cycles before a missing response is declared

Ports:
c_clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
req_valid  in  1  request offered
req_ready  out  1  request accepted this edge when req_valid=1
req_cmd  in  4  calc1 command
req_op1  in  32  first operand
req_op2  in  32  second operand
port_cmd  out  4  to calc1 reqN_cmd_in
port_data  out  32  to calc1 reqN_data_in
port_resp  in  2  from calc1 out_respN
port_out  in  32  from calc1 out_dataN
rsp_valid  out  1  result available
rsp_ready  in  1  result consumed this edge when rsp_valid=1
rsp_code  out  2  captured port_resp; 0 on timeout
rsp_data  out  32  captured port_out; 0 on timeout
rsp_cmd  out  4  command that produced this result
rsp_timeout  out  1  result is a timeout
spurious  out  1  sticky: nonzero port_resp seen outside WAIT
fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, reset=0): state IDLE; FIFO empty; all outputs 0 except req_ready=1. Reset mid-operation abandons the in-flight command and drops all queued entries.
- Enqueue:
  - req_ready = (fifo_count < DEPTH); depends only on occupancy, so it stays low when full even if a pop happens the same edge.
  - req_cmd=0 (NOP) handshakes normally but is discarded, never enqueued.
  - Simultaneous push and pop leaves fifo_count unchanged.
- All port_* and rsp_* outputs are registered.
- States:
  - IDLE: port_cmd=0, port_data=0. Goes to SEND1 when FIFO is non-empty.
  - SEND1 (1 cycle): port_cmd=head cmd, port_data=head op1. Head is popped on the SEND1->SEND2 edge.
  - SEND2 (1 cycle): port_cmd=0, port_data=op2. Goes to WAIT.
  - WAIT: port_cmd=0, port_data=0; timeout counter starts at 0 and increments each cycle.
    - If port_resp!=0 in any of the first TIMEOUT WAIT cycles: capture rsp_code=port_resp, rsp_data=port_out, rsp_cmd, rsp_timeout=0, then go to HOLD.
    - If no response after TIMEOUT cycles: rsp_code=0, rsp_data=0, rsp_timeout=1, then go to HOLD.
  - HOLD: rsp_valid=1 with fields stable. On rsp_ready=1, clear rsp_valid and go to IDLE. A response arriving in the same cycle as a timeout is taken as a response.
- Latency: a request accepted at edge E0 into an empty FIFO in IDLE gives SEND1 visible after E1, SEND2 after E2, WAIT from E3.
- port_resp!=0 in IDLE, SEND1, SEND2 or HOLD is ignored for data and sets spurious, which holds until reset.
- Invalid commands (3, 4, 7..15) are sent unchanged; the calc1 response is passed through.
- Exactly one operation is outstanding per port at any time.

Decomposition:
- Shared package calc1_pkg:
  - CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_LSH=5, CMD_RSH=6
  - RSP_NONE=0, RSP_SUCC=1, RSP_INOF=2, RSP_IERR=3
  - sequencer state encoding and the 68-bit request entry layout {cmd, op1, op2}
- One sub-module, calc1_req_fifo: synchronous FIFO of DEPTH x 68, with push, pop, count and async active-low reset. The FSM, timeout counter and result registers live in the top.

Test Plan:
1. ADD(1), op1=255, op2=1 into empty FIFO -> port shows 1/255 then 0/1. With calc1 returning resp 1, data 256 -> rsp_code=1, rsp_data=256, rsp_cmd=1, rsp_timeout=0.
2. SUB(2), op1=1, op2=2, with calc1 returning 2 (underflow) -> rsp_code=2. Then cmd 3, op1=0, op2=0 with calc1 returning 2 -> rsp_code=2, rsp_cmd=3.
3. port_resp held at 0 -> after 15 WAIT cycles rsp_valid=1, rsp_timeout=1, rsp_code=0, rsp_data=0. Response on exactly the 15th cycle -> rsp_timeout=0.
4. rsp_ready=0; offer 6 ADDs with op1=1..6 -> 5 accepted (1 in flight plus 4 queued), then req_ready=0 and fifo_count=4. Releasing rsp_ready -> results return in order 1..5. A NOP offer is accepted while fifo_count stays unchanged.
5. Pulse port_resp=1 in IDLE -> spurious=1 held, no rsp_valid. Then a normal ADD completes correctly.
6. reset=0 during WAIT with 3 queued -> immediately fifo_count=0, rsp_valid=0, port_cmd=0, spurious=0. After release, a new ADD 2+3 -> rsp_data=5.

Source files
------------

// File: rtl/calc1_pkg.sv
// calc1_pkg: calc1 command/response codes, sequencer state encoding and request entry layout
package calc1_pkg;
  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_LSH = 4'd5;
  localparam logic [3:0] CMD_RSH = 4'd6;
  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_SUCC = 2'd1;
  localparam logic [1:0] RSP_INOF = 2'd2;
  localparam logic [1:0] RSP_IERR = 2'd3;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND1,
    ST_SEND2,
    ST_WAIT,
    ST_HOLD
  } seq_state_e;
  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } req_entry_t;
endpackage

// File: rtl/calc1_req_fifo.sv
// calc1_req_fifo: DEPTH-entry FIFO of whole calc1 operations {cmd, op1, op2} with occupancy count
module calc1_req_fifo
  import calc1_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   c_clk,
  input  logic                   reset,
  input  logic                   push,
  input  req_entry_t             push_data,
  input  logic                   pop,
  output req_entry_t             head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  req_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push_ok, pop_ok;
  always_comb begin
    push_ok  = push && (count_q != CW'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage needs no reset: entries are only read while count is nonzero
  always_ff @(posedge c_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end
  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/calc1_port_sequencer.sv
// calc1_port_sequencer: queues calc1 operations and drives the two-cycle cmd/op1, op2 port protocol,
// returning each response (or a timeout) through a valid/ready result interface.
module calc1_port_sequencer
  import calc1_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   c_clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_cmd,
  input  logic [31:0]            req_op1,
  input  logic [31:0]            req_op2,
  output logic [3:0]             port_cmd,
  output logic [31:0]            port_data,
  input  logic [1:0]             port_resp,
  input  logic [31:0]            port_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_code,
  output logic [31:0]            rsp_data,
  output logic [3:0]             rsp_cmd,
  output logic                   rsp_timeout,
  output logic                   spurious,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  seq_state_e state_q, state_d;
  logic [3:0]    cur_cmd_q, cur_cmd_d, port_cmd_q, port_cmd_d, rsp_cmd_q, rsp_cmd_d;
  logic [31:0]   port_data_q, port_data_d, rsp_data_q, rsp_data_d;
  logic [1:0]    rsp_code_q, rsp_code_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d, spurious_q, spurious_d;
  logic          push, pop, fifo_empty, got_resp;
  req_entry_t    head;
  // NOPs complete the handshake but never occupy a slot
  assign req_ready = (fifo_count < CW'(DEPTH));
  assign push      = req_valid && req_ready && (req_cmd != CMD_NOP);
  assign got_resp  = (port_resp != RSP_NONE);
  calc1_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .c_clk    (c_clk),
    .reset    (reset),
    .push     (push),
    .push_data({req_cmd, req_op1, req_op2}),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );
  always_comb begin
    state_d       = state_q;
    cur_cmd_d     = cur_cmd_q;
    tmo_d         = tmo_q;
    port_cmd_d    = CMD_NOP;
    port_data_d   = '0;
    rsp_valid_d   = rsp_valid_q;
    rsp_code_d    = rsp_code_q;
    rsp_data_d    = rsp_data_q;
    rsp_cmd_d     = rsp_cmd_q;
    rsp_timeout_d = rsp_timeout_q;
    spurious_d    = spurious_q || (got_resp && state_q != ST_WAIT);
    pop           = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        state_d     = ST_SEND1;
        port_cmd_d  = head.cmd;
        port_data_d = head.op1;
        cur_cmd_d   = head.cmd;
      end
      ST_SEND1: begin
        state_d     = ST_SEND2;
        port_data_d = head.op2;
        pop         = 1'b1;
      end
      ST_SEND2: begin
        state_d = ST_WAIT;
        tmo_d   = '0;
      end
      // a response on the last allowed cycle wins over the timeout
      ST_WAIT: if (got_resp || tmo_q == TW'(TIMEOUT - 1)) begin
        state_d       = ST_HOLD;
        rsp_valid_d   = 1'b1;
        rsp_code_d    = port_resp;
        rsp_data_d    = got_resp ? port_out : '0;
        rsp_cmd_d     = cur_cmd_q;
        rsp_timeout_d = !got_resp;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
      ST_HOLD: if (rsp_ready) begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cur_cmd_q     <= '0;
      tmo_q         <= '0;
      port_cmd_q    <= '0;
      port_data_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_code_q    <= '0;
      rsp_data_q    <= '0;
      rsp_cmd_q     <= '0;
      rsp_timeout_q <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_cmd_q     <= cur_cmd_d;
      tmo_q         <= tmo_d;
      port_cmd_q    <= port_cmd_d;
      port_data_q   <= port_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_code_q    <= rsp_code_d;
      rsp_data_q    <= rsp_data_d;
      rsp_cmd_q     <= rsp_cmd_d;
      rsp_timeout_q <= rsp_timeout_d;
      spurious_q    <= spurious_d;
    end
  end
  assign port_cmd    = port_cmd_q;
  assign port_data   = port_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_code    = rsp_code_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_cmd     = rsp_cmd_q;
  assign rsp_timeout = rsp_timeout_q;
  assign spurious    = spurious_q;
endmodule

// File: tb/tb_calc1_port_sequencer.sv
// tb_calc1_port_sequencer: directed scenarios against a small calc1 port responder
module tb_calc1_port_sequencer;
  import calc1_pkg::*;
  logic        c_clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, rsp_ready = 1'b0;
  logic [3:0]  req_cmd = '0, port_cmd, rsp_cmd;
  logic [31:0] req_op1 = '0, req_op2 = '0, port_data, port_out, rsp_data;
  logic [1:0]  port_resp, rsp_code;
  logic        rsp_valid, rsp_timeout, spurious;
  logic [2:0]  fifo_count;
  int n_tests = 0, n_fail = 0;
  logic        m_en = 1'b1;
  int          m_delay = 0, m_phase = 0, m_cnt = 0;
  logic [1:0]  m_resp = '0, force_resp = '0;
  logic [31:0] m_out = '0, m_op1 = '0, m_op2 = '0;
  logic [3:0]  m_cmd = '0;

  assign port_resp = m_resp | force_resp;
  assign port_out  = m_out;

  calc1_port_sequencer #(.DEPTH(4), .TIMEOUT(15)) dut (
    .c_clk(c_clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
    .port_cmd(port_cmd), .port_data(port_data), .port_resp(port_resp), .port_out(port_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code), .rsp_data(rsp_data),
    .rsp_cmd(rsp_cmd), .rsp_timeout(rsp_timeout), .spurious(spurious), .fifo_count(fifo_count)
  );

  always #5 c_clk = ~c_clk;

  function automatic logic [33:0] calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (c)
      CMD_ADD: return {(s[32] ? RSP_INOF : RSP_SUCC), s[31:0]};
      CMD_SUB: return {((a < b) ? RSP_INOF : RSP_SUCC), a - b};
      CMD_LSH: return {RSP_SUCC, a << b[4:0]};
      CMD_RSH: return {RSP_SUCC, a >> b[4:0]};
      default: return {RSP_INOF, 32'd0};
    endcase
  endfunction

  // calc1 port: captures cmd/op1 then op2, answers on WAIT cycle m_delay+1
  always @(negedge c_clk) begin
    if (!reset) begin
      m_phase <= 0;
      m_resp  <= '0;
      m_out   <= '0;
    end else begin
      case (m_phase)
        0: if (port_cmd != 4'd0) begin
          m_cmd   <= port_cmd;
          m_op1   <= port_data;
          m_phase <= 1;
        end
        1: begin
          m_op2   <= port_data;
          m_cnt   <= 0;
          m_phase <= 2;
        end
        2: if (rsp_valid) m_phase <= 0;
        else if (m_en && m_cnt == m_delay) begin
          {m_resp, m_out} <= calc(m_cmd, m_op1, m_op2);
          m_phase <= 3;
        end else m_cnt <= m_cnt + 1;
        default: begin
          m_resp  <= '0;
          m_out   <= '0;
          m_phase <= 0;
        end
      endcase
    end
  end

  task automatic offer(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_cmd = c; req_op1 = a; req_op2 = b;
    @(negedge c_clk);
    req_valid = 1'b0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge c_clk);
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    @(negedge c_clk);
    n_tests++;
    if ({req_ready, rsp_valid, port_cmd, port_data, rsp_code, rsp_data, rsp_cmd, rsp_timeout, spurious, fifo_count}
        !== {1'b1, 1'b0, 4'd0, 32'd0, 2'd0, 32'd0, 4'd0, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b v=%b pc=%h pd=%h code=%h data=%h cmd=%h to=%b sp=%b cnt=%0d want rdy=1 rest 0",
               req_ready, rsp_valid, port_cmd, port_data, rsp_code, rsp_data, rsp_cmd, rsp_timeout, spurious, fifo_count);
    end
    @(negedge c_clk);
    reset = 1'b1;
    @(negedge c_clk);
  endtask

  task automatic test_add();
    bit ok;
    offer(CMD_ADD, 32'd255, 32'd1);
    @(negedge c_clk);
    n_tests++;
    if ({port_cmd, port_data} !== {4'd1, 32'd255}) begin
      n_fail++; $display("FAIL add_send1: got %h/%0d want 1/255", port_cmd, port_data);
    end
    @(negedge c_clk);
    n_tests++;
    if ({port_cmd, port_data} !== {4'd0, 32'd1}) begin
      n_fail++; $display("FAIL add_send2: got %h/%0d want 0/1", port_cmd, port_data);
    end
    @(negedge c_clk);
    n_tests++;
    if ({port_cmd, port_data, rsp_valid} !== {4'd0, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL add_wait: got %h/%0d v=%b want 0/0 v=0", port_cmd, port_data, rsp_valid);
    end
    wait_rsp(ok);
    n_tests++;
    if (!ok || {rsp_code, rsp_data, rsp_cmd, rsp_timeout} !== {2'd1, 32'd256, 4'd1, 1'b0}) begin
      n_fail++; $display("FAIL add_result: ok=%b code=%0d data=%0d cmd=%0d to=%b want 1/256/1/0", ok, rsp_code, rsp_data, rsp_cmd, rsp_timeout);
    end
    ack();
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_ack: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_sub_invalid();
    bit ok;
    offer(CMD_SUB, 32'd1, 32'd2);
    wait_rsp(ok);
    n_tests++;
    if (!ok || {rsp_code, rsp_cmd, rsp_timeout} !== {2'd2, 4'd2, 1'b0}) begin
      n_fail++; $display("FAIL sub_underflow: ok=%b code=%0d cmd=%0d to=%b want 2/2/0", ok, rsp_code, rsp_cmd, rsp_timeout);
    end
    ack();
    offer(4'd3, 32'd0, 32'd0);
    wait_rsp(ok);
    n_tests++;
    if (!ok || {rsp_code, rsp_cmd, rsp_timeout} !== {2'd2, 4'd3, 1'b0}) begin
      n_fail++; $display("FAIL invalid_cmd: ok=%b code=%0d cmd=%0d to=%b want 2/3/0", ok, rsp_code, rsp_cmd, rsp_timeout);
    end
    ack();
  endtask

  task automatic test_timeout();
    m_en = 1'b0;
    offer(CMD_ADD, 32'd5, 32'd6);
    repeat (17) @(negedge c_clk);
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: rsp_valid=%b after 14 WAIT cycles want 0", rsp_valid);
    end
    @(negedge c_clk);
    n_tests++;
    if ({rsp_valid, rsp_timeout, rsp_code, rsp_data, rsp_cmd} !== {1'b1, 1'b1, 2'd0, 32'd0, 4'd1}) begin
      n_fail++; $display("FAIL timeout_result: v=%b to=%b code=%0d data=%0d cmd=%0d want 1/1/0/0/1", rsp_valid, rsp_timeout, rsp_code, rsp_data, rsp_cmd);
    end
    ack();
    m_en = 1'b1;
    m_delay = 14;
    offer(CMD_ADD, 32'd7, 32'd9);
    repeat (17) @(negedge c_clk);
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL late_resp_early: rsp_valid=%b want 0", rsp_valid);
    end
    @(negedge c_clk);
    n_tests++;
    if ({rsp_valid, rsp_timeout, rsp_code, rsp_data} !== {1'b1, 1'b0, 2'd1, 32'd16}) begin
      n_fail++; $display("FAIL late_resp_15th: v=%b to=%b code=%0d data=%0d want 1/0/1/16", rsp_valid, rsp_timeout, rsp_code, rsp_data);
    end
    ack();
    m_delay = 0;
  endtask

  task automatic test_nop();
    bit seen;
    req_valid = 1'b1; req_cmd = CMD_NOP; req_op1 = 32'd99; req_op2 = 32'd1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL nop_ready: req_ready=%b want 1", req_ready);
    end
    @(negedge c_clk);
    req_valid = 1'b0; req_op1 = '0; req_op2 = '0;
    n_tests++;
    if (fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL nop_count: fifo_count=%0d want 0", fifo_count);
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge c_clk);
      seen |= (port_cmd != 4'd0) || rsp_valid;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL nop_issued: port activity=%b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [5:0] acc;
    for (int i = 1; i <= 6; i++) begin
      req_valid = 1'b1; req_cmd = CMD_ADD; req_op1 = 32'(i); req_op2 = 32'd10;
      acc[i-1] = req_ready;
      @(negedge c_clk);
    end
    req_valid = 1'b0; req_cmd = '0;
    n_tests++;
    if ({acc, fifo_count, req_ready} !== {6'b011111, 3'd4, 1'b0}) begin
      n_fail++; $display("FAIL full_accept: acc=%b cnt=%0d rdy=%b want 011111/4/0", acc, fifo_count, req_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      wait_rsp(ok);
      n_tests++;
      if (!ok || {rsp_data, rsp_cmd, rsp_code} !== {32'(k + 10), 4'd1, 2'd1}) begin
        n_fail++; $display("FAIL order_%0d: ok=%b data=%0d cmd=%0d code=%0d want %0d/1/1", k, ok, rsp_data, rsp_cmd, rsp_code, k + 10);
      end
      ack();
    end
    n_tests++;
    if ({fifo_count, spurious} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL drain_end: cnt=%0d sp=%b want 0/0", fifo_count, spurious);
    end
  endtask

  task automatic test_spurious();
    bit ok;
    force_resp = 2'd1;
    @(negedge c_clk);
    force_resp = 2'd0;
    n_tests++;
    if ({spurious, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL spurious_set: sp=%b v=%b want 1/0", spurious, rsp_valid);
    end
    repeat (3) @(negedge c_clk);
    n_tests++;
    if ({spurious, rsp_valid, port_cmd} !== {2'b10, 4'd0}) begin
      n_fail++; $display("FAIL spurious_hold: sp=%b v=%b pc=%h want 1/0/0", spurious, rsp_valid, port_cmd);
    end
    offer(CMD_ADD, 32'd7, 32'd8);
    wait_rsp(ok);
    n_tests++;
    if (!ok || {rsp_code, rsp_data, rsp_timeout} !== {2'd1, 32'd15, 1'b0}) begin
      n_fail++; $display("FAIL spurious_then_add: ok=%b code=%0d data=%0d to=%b want 1/15/0", ok, rsp_code, rsp_data, rsp_timeout);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    bit ok;
    m_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_cmd = CMD_ADD; req_op1 = 32'(i); req_op2 = 32'd1;
      @(negedge c_clk);
    end
    req_valid = 1'b0; req_cmd = '0;
    n_tests++;
    if (fifo_count !== 3'd3) begin
      n_fail++; $display("FAIL mid_queued: fifo_count=%0d want 3", fifo_count);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({fifo_count, rsp_valid, port_cmd, spurious, req_ready} !== {3'd0, 1'b0, 4'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL mid_reset: cnt=%0d v=%b pc=%h sp=%b rdy=%b want 0/0/0/0/1", fifo_count, rsp_valid, port_cmd, spurious, req_ready);
    end
    @(negedge c_clk);
    reset = 1'b1;
    m_en = 1'b1;
    @(negedge c_clk);
    offer(CMD_ADD, 32'd2, 32'd3);
    wait_rsp(ok);
    n_tests++;
    if (!ok || {rsp_code, rsp_data, rsp_cmd} !== {2'd1, 32'd5, 4'd1}) begin
      n_fail++; $display("FAIL post_reset_add: ok=%b code=%0d data=%0d cmd=%0d want 1/5/1", ok, rsp_code, rsp_data, rsp_cmd);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_invalid();
    test_timeout();
    test_nop();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
